// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the riscv memory controller: FSM state encoding,
// wait-state limits and the data-address legality check.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int MAX_WAIT_STATES = 7;
  localparam int WAIT_CNT_W      = 3;

  // A data address is legal when word aligned and inside the data memory window.
  function automatic logic addr_ok(input logic [63:0] a, input int unsigned daddr_bits);
    return (a[1:0] == 2'b00) && ((a >> (daddr_bits + 2)) == 64'd0);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter that times the wait states of a data access; o_done is
// high while the count sits at zero.
module mem_wait_timer
  import riscv_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [WAIT_CNT_W-1:0] i_value,
  input  logic                  i_en,
  output logic                  o_done
);

  logic [WAIT_CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/riscv_mem_ctrl.sv
// Memory controller between the riscv core and its instruction/data memories:
// boot-loads imem while the core is held off, then serves fetches and timed data accesses.
module riscv_mem_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int BUS_WIDTH   = 32,
  parameter int IADDR_BITS  = 10,
  parameter int DADDR_BITS  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  boot_valid,
  input  logic [BUS_WIDTH-1:0]  boot_data,
  input  logic                  boot_last,
  output logic                  boot_ready,
  output logic                  core_run,
  input  logic [BUS_WIDTH-1:0]  iaddr,
  output logic [BUS_WIDTH-1:0]  idata,
  input  logic                  iwr,
  input  logic [BUS_WIDTH-1:0]  addr,
  input  logic                  re,
  input  logic                  wr,
  input  logic [BUS_WIDTH-1:0]  wdata,
  output logic [BUS_WIDTH-1:0]  rdata,
  output logic                  dready,
  output logic                  err,
  output logic [IADDR_BITS-1:0] imem_addr,
  output logic                  imem_wr,
  output logic [BUS_WIDTH-1:0]  imem_wdata,
  input  logic [BUS_WIDTH-1:0]  imem_rdata,
  output logic [DADDR_BITS-1:0] dmem_addr,
  output logic                  dmem_re,
  output logic                  dmem_wr,
  output logic [BUS_WIDTH-1:0]  dmem_wdata,
  input  logic [BUS_WIDTH-1:0]  dmem_rdata
);

  localparam logic [IADDR_BITS-1:0] LP_IMEM_LAST = '1;
  localparam logic [WAIT_CNT_W-1:0] LP_WAIT_LOAD =
    (WAIT_STATES == 0) ? WAIT_CNT_W'(0) : WAIT_CNT_W'(WAIT_STATES - 1);
  localparam logic LP_NO_WAIT = (WAIT_STATES == 0);

  state_t                r_state;
  state_t                w_next;
  logic [IADDR_BITS-1:0] r_boot_cnt;
  logic                  r_is_rd;
  logic                  r_err;
  logic [BUS_WIDTH-1:0]  r_rdata;
  logic                  w_sample;
  logic                  w_ok;
  logic                  w_timer_done;
  logic                  w_rd_done;
  logic                  w_unused_iaddr;

  assign w_ok           = addr_ok(64'(addr), DADDR_BITS);
  assign w_unused_iaddr = ^{iaddr[BUS_WIDTH-1:IADDR_BITS+2], iaddr[1:0]};

  assign idata      = imem_rdata;
  assign dmem_addr  = addr[DADDR_BITS+1:2];
  assign dmem_wdata = wdata;

  mem_wait_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_sample),
    .i_value (LP_WAIT_LOAD),
    .i_en    (r_state == ST_WAIT),
    .o_done  (w_timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  // The counter parks on the last index once memory is full instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_boot_cnt <= '0;
    end else if ((r_state == ST_BOOT) && boot_valid && (r_boot_cnt != LP_IMEM_LAST)) begin
      r_boot_cnt <= r_boot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_rd <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_sample) begin
      r_is_rd <= re & ~wr;
      r_err   <= ~w_ok;
    end
  end

  // The synchronous dmem presents read data during DONE; it is forwarded then and held after.
  assign w_rd_done = (r_state == ST_DONE) && r_is_rd && !r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_rd_done) begin
      r_rdata <= dmem_rdata;
    end
  end

  assign rdata = w_rd_done ? dmem_rdata : r_rdata;

  always_comb begin
    w_next     = r_state;
    boot_ready = 1'b0;
    core_run   = 1'b0;
    imem_addr  = iaddr[IADDR_BITS+1:2];
    imem_wr    = 1'b0;
    imem_wdata = wdata;
    dmem_re    = 1'b0;
    dmem_wr    = 1'b0;
    dready     = 1'b0;
    err        = 1'b0;
    w_sample   = 1'b0;
    unique case (r_state)
      ST_BOOT: begin
        boot_ready = 1'b1;
        imem_addr  = r_boot_cnt;
        imem_wdata = boot_data;
        if (boot_valid) begin
          imem_wr = 1'b1;
          if (boot_last || (r_boot_cnt == LP_IMEM_LAST)) begin
            w_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        core_run = 1'b1;
        imem_wr  = iwr;
        if (re || wr) begin
          w_sample = 1'b1;
          dmem_wr  = wr & w_ok;
          dmem_re  = LP_NO_WAIT & re & ~wr & w_ok;
          w_next   = LP_NO_WAIT ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        core_run = 1'b1;
        imem_wr  = iwr;
        if (w_timer_done) begin
          dmem_re = r_is_rd & ~r_err;
          w_next  = ST_DONE;
        end
      end
      ST_DONE: begin
        core_run = 1'b1;
        imem_wr  = iwr;
        dready   = 1'b1;
        err      = r_err;
        w_next   = ST_RUN;
      end
      default: w_next = ST_BOOT;
    endcase
  end

endmodule

// File: tb/tb_riscv_mem_ctrl.sv
// Bench for riscv_mem_ctrl: two instances (2 and 0 wait states) with behavioural memories,
// checked against a reference model of memory contents, latency and error rules.
module tb_riscv_mem_ctrl;

  localparam int BW  = 32;
  localparam int IAB = 10;
  localparam int DAB = 10;
  localparam int WS  = 2;
  localparam int ZIA = 2;

  int checks = 0;
  int passed = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic           reset, boot_valid, boot_last, boot_ready, core_run, iwr, re, wr, dready, err;
  logic [BW-1:0]  boot_data, iaddr, idata, addr, wdata, rdata, imem_wdata, imem_rdata, dmem_wdata, dmem_rdata;
  logic [IAB-1:0] imem_addr;
  logic [DAB-1:0] dmem_addr;
  logic           imem_wr, dmem_re, dmem_wr;

  // zero-wait, tiny-imem instance signals
  logic           z_reset, z_boot_valid, z_boot_last, z_boot_ready, z_core_run, z_iwr, z_re, z_wr, z_dready, z_err;
  logic [BW-1:0]  z_boot_data, z_iaddr, z_idata, z_addr, z_wdata, z_rdata, z_imem_wdata, z_imem_rdata, z_dmem_wdata, z_dmem_rdata;
  logic [ZIA-1:0] z_imem_addr;
  logic [DAB-1:0] z_dmem_addr;
  logic           z_imem_wr, z_dmem_re, z_dmem_wr;

  riscv_mem_ctrl #(.BUS_WIDTH(BW), .IADDR_BITS(IAB), .DADDR_BITS(DAB), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset), .boot_valid(boot_valid), .boot_data(boot_data), .boot_last(boot_last),
    .boot_ready(boot_ready), .core_run(core_run), .iaddr(iaddr), .idata(idata), .iwr(iwr),
    .addr(addr), .re(re), .wr(wr), .wdata(wdata), .rdata(rdata), .dready(dready), .err(err),
    .imem_addr(imem_addr), .imem_wr(imem_wr), .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_wr(dmem_wr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata)
  );

  riscv_mem_ctrl #(.BUS_WIDTH(BW), .IADDR_BITS(ZIA), .DADDR_BITS(DAB), .WAIT_STATES(0)) u_dut_z (
    .clk(clk), .reset(z_reset), .boot_valid(z_boot_valid), .boot_data(z_boot_data), .boot_last(z_boot_last),
    .boot_ready(z_boot_ready), .core_run(z_core_run), .iaddr(z_iaddr), .idata(z_idata), .iwr(z_iwr),
    .addr(z_addr), .re(z_re), .wr(z_wr), .wdata(z_wdata), .rdata(z_rdata), .dready(z_dready), .err(z_err),
    .imem_addr(z_imem_addr), .imem_wr(z_imem_wr), .imem_wdata(z_imem_wdata), .imem_rdata(z_imem_rdata),
    .dmem_addr(z_dmem_addr), .dmem_re(z_dmem_re), .dmem_wr(z_dmem_wr), .dmem_wdata(z_dmem_wdata),
    .dmem_rdata(z_dmem_rdata)
  );

  // behavioural synchronous memories with traffic counters
  logic [BW-1:0]  imem [0:(1<<IAB)-1];
  logic [BW-1:0]  dmem [0:(1<<DAB)-1];
  logic [BW-1:0]  z_imem [0:(1<<ZIA)-1];
  logic [BW-1:0]  z_dmem [0:(1<<DAB)-1];
  int             imem_wr_cnt = 0, dmem_re_cnt = 0, dmem_wr_cnt = 0;
  int             z_imem_wr_cnt = 0, z_dmem_re_cnt = 0, z_dmem_wr_cnt = 0;
  logic [IAB-1:0] imem_last_waddr = '1;

  always @(posedge clk) begin
    if (imem_wr) begin
      imem[imem_addr] <= imem_wdata;
      imem_wr_cnt     <= imem_wr_cnt + 1;
      imem_last_waddr <= imem_addr;
    end
    imem_rdata <= imem[imem_addr];
    if (dmem_wr) begin
      dmem[dmem_addr] <= dmem_wdata;
      dmem_wr_cnt     <= dmem_wr_cnt + 1;
    end
    if (dmem_re) begin
      dmem_rdata  <= dmem[dmem_addr];
      dmem_re_cnt <= dmem_re_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (z_imem_wr) begin
      z_imem[z_imem_addr] <= z_imem_wdata;
      z_imem_wr_cnt       <= z_imem_wr_cnt + 1;
    end
    z_imem_rdata <= z_imem[z_imem_addr];
    if (z_dmem_wr) begin
      z_dmem[z_dmem_addr] <= z_dmem_wdata;
      z_dmem_wr_cnt       <= z_dmem_wr_cnt + 1;
    end
    if (z_dmem_re) begin
      z_dmem_rdata  <= z_dmem[z_dmem_addr];
      z_dmem_re_cnt <= z_dmem_re_cnt + 1;
    end
  end

  // reference model state
  logic [BW-1:0] ref_imem [int];
  logic [BW-1:0] ref_dmem [int];

  function automatic logic exp_err(input logic [31:0] a, input int dbits);
    longint lim;
    lim = longint'(1) << (dbits + 2);
    return ((a % 4) != 0) || (longint'(a) >= lim);
  endfunction

  task automatic do_reset();
    reset = 1'b1; boot_valid = 1'b0; boot_last = 1'b0; re = 1'b0; wr = 1'b0; iwr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // drives one request on the main DUT in a fresh RUN cycle and waits for dready
  task automatic do_req(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d,
                        output int lat, output logic e, output logic [31:0] rd,
                        output logic wr_seen, output logic got);
    @(posedge clk);
    #1;
    addr = a; re = r; wr = w; wdata = d;
    #1 wr_seen = dmem_wr;
    got = 1'b0; lat = 0; e = 1'bx; rd = 'x;
    @(posedge clk);
    for (int i = 1; i <= 20 && !got; i++) begin
      #1;
      if (dready) begin
        got = 1'b1; lat = i; e = err; rd = rdata;
      end else begin
        @(posedge clk);
      end
    end
    re = 1'b0; wr = 1'b0;
  endtask

  task automatic z_do_req(input logic [31:0] a, input logic r, input logic w, input logic [31:0] d,
                          output int lat, output logic e, output logic [31:0] rd,
                          output logic wr_seen, output logic got);
    @(posedge clk);
    #1;
    z_addr = a; z_re = r; z_wr = w; z_wdata = d;
    #1 wr_seen = z_dmem_wr;
    got = 1'b0; lat = 0; e = 1'bx; rd = 'x;
    @(posedge clk);
    for (int i = 1; i <= 20 && !got; i++) begin
      #1;
      if (z_dready) begin
        got = 1'b1; lat = i; e = z_err; rd = z_rdata;
      end else begin
        @(posedge clk);
      end
    end
    z_re = 1'b0; z_wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (core_run !== 1'b0) $display("FAIL reset_core_run got %b want 0", core_run); else passed++;
    checks++; if (boot_ready !== 1'b1) $display("FAIL reset_boot_ready got %b want 1", boot_ready); else passed++;
    checks++; if ({dready, err} !== 2'b00) $display("FAIL reset_dready_err got %b want 00", {dready, err}); else passed++;
    checks++; if (rdata !== 32'd0) $display("FAIL reset_rdata got %h want 0", rdata); else passed++;
    checks++; if ({imem_wr, dmem_re, dmem_wr} !== 3'b000) $display("FAIL reset_enables got %b want 000", {imem_wr, dmem_re, dmem_wr}); else passed++;
  endtask

  task automatic test_boot();
    int c0;
    c0 = imem_wr_cnt;
    for (int i = 0; i < 4; i++) begin
      boot_valid = 1'b1; boot_data = 32'(8'h11 * (i + 1)); boot_last = (i == 3);
      #1;
      checks++; if (boot_ready !== 1'b1 || core_run !== 1'b0) $display("FAIL boot_beat%0d ready/run got %b%b want 10", i, boot_ready, core_run); else passed++;
      checks++; if (imem_wr !== 1'b1 || imem_addr !== IAB'(i)) $display("FAIL boot_waddr%0d got wr=%b addr=%0d want wr=1 addr=%0d", i, imem_wr, imem_addr, i); else passed++;
      ref_imem[i] = boot_data;
      @(posedge clk);
      #1 boot_valid = 1'b0; boot_last = 1'b0;
    end
    checks++; if (core_run !== 1'b1 || boot_ready !== 1'b0) $display("FAIL boot_run_after_last got run=%b ready=%b want 1 0", core_run, boot_ready); else passed++;
    checks++; if (imem_wr_cnt - c0 !== 4) $display("FAIL boot_write_count got %0d want 4", imem_wr_cnt - c0); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem[i] !== ref_imem[i]) $display("FAIL boot_imem%0d got %h want %h", i, imem[i], ref_imem[i]); else passed++;
    end
  endtask

  task automatic test_fetch();
    int k;
    logic [31:0] v;
    for (int n = 0; n < 6; n++) begin
      if (n % 2 == 1) begin
        k = $urandom_range(4, (1 << IAB) - 1); v = $urandom;
        @(posedge clk);
        #1 iaddr = 32'(k * 4); wdata = v; iwr = 1'b1;
        @(posedge clk);
        #1 iwr = 1'b0;
        ref_imem[k] = v;
      end else begin
        k = $urandom_range(0, 3);
      end
      @(posedge clk);
      #1 iaddr = 32'(k * 4) | 32'($urandom_range(0, 3));
      #1;
      checks++; if (imem_addr !== IAB'(k)) $display("FAIL fetch_addr got %0d want %0d", imem_addr, k); else passed++;
      @(posedge clk);
      #1;
      checks++; if (idata !== ref_imem[k]) $display("FAIL fetch_data[%0d] got %h want %h", k, idata, ref_imem[k]); else passed++;
    end
  endtask

  task automatic test_write_read();
    int lat; logic e, ws, got; logic [31:0] rd;
    do_req(32'h10, 1'b0, 1'b1, 32'hDEADBEEF, lat, e, rd, ws, got);
    ref_dmem[4] = 32'hDEADBEEF;
    checks++; if (got !== 1'b1) $display("FAIL wr_timeout got no dready want dready"); else passed++;
    checks++; if (ws !== 1'b1) $display("FAIL wr_pulse_at_sample got %b want 1", ws); else passed++;
    checks++; if (lat !== WS + 1 || e !== 1'b0) $display("FAIL wr_latency got lat=%0d err=%b want lat=%0d err=0", lat, e, WS + 1); else passed++;
    do_req(32'h10, 1'b1, 1'b0, 32'h0, lat, e, rd, ws, got);
    checks++; if (got !== 1'b1 || lat !== WS + 1) $display("FAIL rd_latency got got=%b lat=%0d want lat=%0d", got, lat, WS + 1); else passed++;
    checks++; if (rd !== ref_dmem[4] || e !== 1'b0) $display("FAIL rd_data got %h err=%b want %h err=0", rd, e, ref_dmem[4]); else passed++;
  endtask

  task automatic test_errors();
    int lat, r0, w0; logic e, ws, got; logic [31:0] rd;
    logic [31:0] bad [3];
    logic        bad_w [3];
    bad[0] = 32'h13; bad_w[0] = 1'b0;
    bad[1] = 32'(1 << (DAB + 2)); bad_w[1] = 1'b0;
    bad[2] = 32'h12; bad_w[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r0 = dmem_re_cnt; w0 = dmem_wr_cnt;
      do_req(bad[i], ~bad_w[i], bad_w[i], 32'h0BAD0BAD, lat, e, rd, ws, got);
      checks++; if (got !== 1'b1 || lat !== WS + 1 || e !== 1'b1) $display("FAIL err_req%0d got got=%b lat=%0d err=%b want lat=%0d err=1", i, got, lat, e, WS + 1); else passed++;
      checks++; if (dmem_re_cnt !== r0 || dmem_wr_cnt !== w0 || ws !== 1'b0) $display("FAIL err_no_access%0d got re+%0d wr+%0d want none", i, dmem_re_cnt - r0, dmem_wr_cnt - w0); else passed++;
    end
  endtask

  task automatic test_both();
    int lat, r0, w0; logic e, ws, got; logic [31:0] rd;
    r0 = dmem_re_cnt; w0 = dmem_wr_cnt;
    do_req(32'h20, 1'b1, 1'b1, 32'h5, lat, e, rd, ws, got);
    ref_dmem[8] = 32'h5;
    checks++; if (got !== 1'b1 || ws !== 1'b1 || e !== 1'b0) $display("FAIL both_write got got=%b wr=%b err=%b want 1 1 0", got, ws, e); else passed++;
    checks++; if (dmem_re_cnt - r0 !== 0 || dmem_wr_cnt - w0 !== 1) $display("FAIL both_traffic got re+%0d wr+%0d want re+0 wr+1", dmem_re_cnt - r0, dmem_wr_cnt - w0); else passed++;
    do_req(32'h20, 1'b1, 1'b0, 32'h0, lat, e, rd, ws, got);
    checks++; if (rd !== 32'h5) $display("FAIL both_readback got %h want 00000005", rd); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, kind, idx, r0, w0, exp_r, exp_w;
    logic e, ws, got, r, w, ee;
    logic [31:0] a, d, rd;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      do_req(32'h100 + 32'(4 * i), 1'b0, 1'b1, d, lat, e, rd, ws, got);
      ref_dmem[(32'h100 >> 2) + i] = d;
    end
    r0 = dmem_re_cnt; w0 = dmem_wr_cnt; exp_r = 0; exp_w = 0;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3); idx = $urandom_range(0, 7); d = $urandom;
      a = 32'h100 + 32'(4 * idx);
      r = 1'b1; w = 1'b0;
      case (kind)
        0: begin r = $urandom_range(0, 1); w = 1'b1; end
        1: ;
        2: begin a = a | 32'($urandom_range(1, 3)); w = $urandom_range(0, 1); end
        default: begin a = (32'($urandom_range(1, 255)) << (DAB + 2)) | (32'($urandom) & 32'hFFC); w = $urandom_range(0, 1); end
      endcase
      ee = exp_err(a, DAB);
      do_req(a, r, w, d, lat, e, rd, ws, got);
      checks++; if (got !== 1'b1 || lat !== WS + 1 || e !== ee) $display("FAIL b2b%0d a=%h got lat=%0d err=%b want lat=%0d err=%b", n, a, lat, e, WS + 1, ee); else passed++;
      if (!ee && w) begin
        ref_dmem[int'(a >> 2)] = d; exp_w++;
      end else if (!ee) begin
        exp_r++;
        checks++; if (rd !== ref_dmem[int'(a >> 2)]) $display("FAIL b2b_rd%0d a=%h got %h want %h", n, a, rd, ref_dmem[int'(a >> 2)]); else passed++;
      end
    end
    checks++; if (dmem_re_cnt - r0 !== exp_r || dmem_wr_cnt - w0 !== exp_w) $display("FAIL b2b_traffic got re=%0d wr=%0d want re=%0d wr=%0d", dmem_re_cnt - r0, dmem_wr_cnt - w0, exp_r, exp_w); else passed++;
  endtask

  task automatic test_reset_in_wait();
    logic seen;
    @(posedge clk);
    #1 addr = 32'h10; re = 1'b1; wr = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1; re = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (core_run !== 1'b0 || boot_ready !== 1'b1) $display("FAIL rst_wait_state got run=%b ready=%b want 0 1", core_run, boot_ready); else passed++;
    seen = dready;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 seen = seen | dready | core_run;
    end
    checks++; if (seen !== 1'b0) $display("FAIL rst_wait_no_dready got %b want 0", seen); else passed++;
    boot_valid = 1'b1; boot_data = 32'hCAFE0001; boot_last = 1'b1;
    @(posedge clk);
    #1 boot_valid = 1'b0; boot_last = 1'b0;
    ref_imem[0] = 32'hCAFE0001;
    checks++; if (imem_last_waddr !== '0 || imem[0] !== 32'hCAFE0001) $display("FAIL rst_boot_cnt got addr=%0d data=%h want 0 cafe0001", imem_last_waddr, imem[0]); else passed++;
    checks++; if (core_run !== 1'b1) $display("FAIL rst_reboot_run got %b want 1", core_run); else passed++;
  endtask

  task automatic test_zero_wait();
    int lat, c0, r0, w0; logic e, ws, got; logic [31:0] rd;
    z_reset = 1'b1;
    @(posedge clk);
    #1 z_reset = 1'b0;
    c0 = z_imem_wr_cnt;
    for (int i = 0; i < 5; i++) begin
      z_boot_valid = 1'b1; z_boot_data = 32'hA0 + 32'(i); z_boot_last = 1'b0;
      #1;
      checks++; if (z_boot_ready !== (i < 4)) $display("FAIL z_boot_ready%0d got %b want %b", i, z_boot_ready, (i < 4)); else passed++;
      @(posedge clk);
      #1 z_boot_valid = 1'b0;
    end
    checks++; if (z_imem_wr_cnt - c0 !== 4 || z_imem[0] !== 32'hA0) $display("FAIL z_boot_full got writes=%0d imem0=%h want 4 000000a0", z_imem_wr_cnt - c0, z_imem[0]); else passed++;
    checks++; if (z_core_run !== 1'b1) $display("FAIL z_run got %b want 1", z_core_run); else passed++;
    r0 = z_dmem_re_cnt; w0 = z_dmem_wr_cnt;
    z_do_req(32'h20, 1'b1, 1'b1, 32'h5, lat, e, rd, ws, got);
    checks++; if (got !== 1'b1 || lat !== 1 || ws !== 1'b1 || e !== 1'b0) $display("FAIL z_both got got=%b lat=%0d wr=%b err=%b want 1 1 1 0", got, lat, ws, e); else passed++;
    checks++; if (z_dmem_re_cnt !== r0 || z_dmem_wr_cnt - w0 !== 1 || z_dmem[8] !== 32'h5) $display("FAIL z_both_traffic got re+%0d wr+%0d mem=%h want 0 1 5", z_dmem_re_cnt - r0, z_dmem_wr_cnt - w0, z_dmem[8]); else passed++;
    z_do_req(32'h20, 1'b1, 1'b0, 32'h0, lat, e, rd, ws, got);
    checks++; if (got !== 1'b1 || lat !== 1 || rd !== 32'h5) $display("FAIL z_read got lat=%0d data=%h want 1 00000005", lat, rd); else passed++;
    z_do_req(32'h21, 1'b1, 1'b0, 32'h0, lat, e, rd, ws, got);
    checks++; if (got !== 1'b1 || lat !== 1 || e !== 1'b1) $display("FAIL z_err got lat=%0d err=%b want 1 1", lat, e); else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; boot_valid = 1'b0; boot_data = '0; boot_last = 1'b0; iaddr = '0; iwr = 1'b0;
    addr = '0; re = 1'b0; wr = 1'b0; wdata = '0;
    z_reset = 1'b1; z_boot_valid = 1'b0; z_boot_data = '0; z_boot_last = 1'b0; z_iaddr = '0; z_iwr = 1'b0;
    z_addr = '0; z_re = 1'b0; z_wr = 1'b0; z_wdata = '0;
    test_reset();
    test_boot();
    test_fetch();
    test_write_read();
    test_errors();
    test_both();
    test_back_to_back();
    test_reset_in_wait();
    test_zero_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
